// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: an instruction-fetch port (read only) and a
// load/store port share one downstream memory port. One transaction is in
// flight at a time. Simultaneous requests are resolved round-robin against
// whichever requester completed most recently.
//
// Handshake rules (all ports): a requester raises req and holds its fields
// stable until it sees addr_ok high in the same cycle; the fields are
// sampled only in that cycle. The response arrives later as a one-cycle
// data_ok pulse, with rdata valid only in that cycle and 0 otherwise.
// Downstream, mem_req stays high with stable fields until mem_addr_ok,
// then the arbiter waits for mem_data_ok. Downstream handshakes that
// arrive in a phase where they are not expected are ignored.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,

    // instruction-fetch requester
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    // load/store requester
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    // shared downstream port
    output logic                mem_req,
    output logic                mem_wr,
    output logic [1:0]          mem_size,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // owner encoding shared by owner and last_owner
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // fetches are always full-word reads
    localparam logic [1:0] INST_SIZE = 2'd2;

    state_t              state;
    state_t              state_next;
    logic                owner;
    logic                last_owner;
    logic                grant_inst;
    logic                grant_data;
    logic                resp_done;

    logic                lat_wr;
    logic [1:0]          lat_size;
    logic [DATA_W/8-1:0] lat_wstrb;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    // next-state, grant and response decode; all handshake outputs are
    // combinational from state and the current-cycle inputs
    always_comb begin
        state_next   = state;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        resp_done    = 1'b0;
        mem_req      = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;
        case (state)
            IDLE: begin
                // resetn gating keeps addr_ok low while reset is asserted,
                // even though state already reads IDLE
                if (resetn) begin
                    if (inst_req && (!data_req || last_owner == OWN_DATA)) begin
                        grant_inst = 1'b1;
                    end else if (data_req) begin
                        grant_data = 1'b1;
                    end
                end
                if (grant_inst || grant_data) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (mem_data_ok) begin
                    resp_done  = 1'b1;
                    state_next = IDLE;
                    if (owner == OWN_INST) begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = mem_rdata;
                    end else begin
                        data_data_ok = 1'b1;
                        // a store completes with no read data
                        if (!lat_wr) begin
                            data_rdata = mem_rdata;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign busy         = (state != IDLE);

    // the downstream request fields come straight from the latch, so they
    // cannot move while mem_req waits for mem_addr_ok
    assign mem_wr    = lat_wr;
    assign mem_size  = lat_size;
    assign mem_wstrb = lat_wstrb;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // capture the granted requester's fields and remember who owns the slot
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner     <= OWN_INST;
            lat_wr    <= 1'b0;
            lat_size  <= 2'd0;
            lat_wstrb <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant_inst) begin
            owner     <= OWN_INST;
            lat_wr    <= 1'b0;
            lat_size  <= INST_SIZE;
            lat_wstrb <= '0;
            lat_addr  <= inst_addr;
            lat_wdata <= '0;
        end else if (grant_data) begin
            owner     <= OWN_DATA;
            lat_wr    <= data_wr;
            lat_size  <= data_size;
            lat_wstrb <= data_wstrb;
            lat_addr  <= data_addr;
            lat_wdata <= data_wdata;
        end
    end

    // round-robin history: updated only when a transaction completes, and
    // reset to the data side so the fetch port wins the first tie
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_owner <= OWN_DATA;
        end else if (resp_done) begin
            last_owner <= owner;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reset state, a table of handshake
// vectors covering ties and stray downstream handshakes, hand-written
// fetch/store/reset/stream sequences, and a randomized run checked against
// a transaction-level reference model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // vector order: {inst_addr_ok, data_addr_ok, mem_req, busy, inst_data_ok, data_data_ok}
    typedef struct packed {
        logic        ireq;
        logic        dreq;
        logic        mao;
        logic        mdo;
        logic [31:0] rd;
        logic [5:0]  hs;
        logic [31:0] ir;
        logic [31:0] dr;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [5:0] hs_now();
        return {inst_addr_ok, data_addr_ok, mem_req, busy, inst_data_ok, data_data_ok};
    endfunction

    function automatic logic [70:0] mem_fields();
        return {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    // advance one full cycle, landing on the falling edge
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // reference model: one optional in-flight transaction
    logic        m_has, m_sent, m_who, m_last;
    logic [70:0] m_fields;

    task automatic model_reset();
        m_has  = 1'b0;
        m_sent = 1'b0;
        m_who  = 1'b0;
        m_last = 1'b1;      // data served "last", fetch wins first tie
        m_fields = '0;
    endtask

    // compare the current cycle against the model, then advance the model
    task automatic model_cycle(output logic gi, output logic gd);
        logic       done;
        logic [5:0] exp_hs;
        logic [31:0] exp_ir, exp_dr;
        gi = !m_has && inst_req && (!data_req || m_last == 1'b1);
        gd = !m_has && data_req && !gi;
        done = m_has && m_sent && mem_data_ok;
        exp_hs = {gi, gd, m_has && !m_sent, m_has, done && !m_who, done && m_who};
        exp_ir = (done && !m_who) ? mem_rdata : 32'h0;
        exp_dr = (done && m_who && !m_fields[70]) ? mem_rdata : 32'h0;
        chk("rand_handshake", hs_now(), exp_hs);
        chk("rand_rdata", {inst_rdata, data_rdata}, {exp_ir, exp_dr});
        if (m_has && !m_sent) chk("rand_mem_fields", mem_fields(), m_fields);
        if (done) begin
            m_has  = 1'b0;
            m_last = m_who;
        end else if (m_has && !m_sent && mem_addr_ok) begin
            m_sent = 1'b1;
        end else if (gi) begin
            m_has = 1'b1; m_sent = 1'b0; m_who = 1'b0;
            m_fields = {1'b0, 2'd2, 4'h0, inst_addr, 32'h0};
        end else if (gd) begin
            m_has = 1'b1; m_sent = 1'b0; m_who = 1'b1;
            m_fields = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
        end
    endtask

    initial begin
        logic        gi, gd;
        logic [31:0] inflight;
        int          prev_ok, n_ok, n_gnt;

        // ---------------- reset state ----------------
        idle_inputs();
        resetn    = 1'b0;
        inst_req  = 1'b1;
        data_req  = 1'b1;
        #1;
        chk("reset_handshake", hs_now(), 6'b0);
        chk("reset_rdata", {inst_rdata, data_rdata}, 64'h0);
        chk("reset_mem_fields", mem_fields(), 71'h0);
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        resetn = 1'b1;

        // ---------------- table: ties, round-robin, stray handshakes ----------------
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        6'b100000, 32'h0,        32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        6'b001100, 32'h0,        32'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h11112222, 6'b000110, 32'h11112222, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        6'b010000, 32'h0,        32'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 6'b001100, 32'h0,        32'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        6'b000100, 32'h0,        32'h0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h33334444, 6'b000101, 32'h0,        32'h33334444};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        6'b100000, 32'h0,        32'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h55555555, 6'b001100, 32'h0,        32'h0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        6'b001100, 32'h0,        32'h0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h66667777, 6'b000110, 32'h66667777, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h88888888, 6'b010000, 32'h0,        32'h0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 6'b001100, 32'h0,        32'h0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        6'b001100, 32'h0,        32'h0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h99999999, 6'b000101, 32'h0,        32'h99999999};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAAAAAA, 6'b000000, 32'h0,        32'h0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 32'h0,        32'h0};
        data_addr = 32'h1C002000;
        inst_addr = 32'h1C000100;
        for (int i = 0; i < 17; i++) begin
            inst_req    = tbl[i].ireq;
            data_req    = tbl[i].dreq;
            mem_addr_ok = tbl[i].mao;
            mem_data_ok = tbl[i].mdo;
            mem_rdata   = tbl[i].rd;
            #1;
            chk($sformatf("tbl%0d_handshake", i), hs_now(), tbl[i].hs);
            chk($sformatf("tbl%0d_rdata", i), {inst_rdata, data_rdata}, {tbl[i].ir, tbl[i].dr});
            next_cycle();
        end

        // ---------------- single fetch ----------------
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'h1C000000;
        #1;
        chk("fetch_addr_ok", hs_now(), 6'b100000);
        next_cycle();
        idle_inputs();
        mem_addr_ok = 1'b1;
        #1;
        chk("fetch_mem_req", {mem_req, busy}, 2'b11);
        chk("fetch_mem_fields", mem_fields(), {1'b0, 2'd2, 4'h0, 32'h1C000000, 32'h0});
        next_cycle();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h02800C0C;
        #1;
        chk("fetch_data_ok", hs_now(), 6'b000110);
        chk("fetch_rdata", {inst_rdata, data_rdata}, {32'h02800C0C, 32'h0});
        next_cycle();
        idle_inputs();
        #1;
        chk("fetch_back_idle", hs_now(), 6'b000000);

        // ---------------- store with delayed mem_addr_ok ----------------
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd0;
        data_wstrb = 4'h2;
        data_addr  = 32'h1C001001;
        data_wdata = 32'h0000AB00;
        #1;
        chk("store_addr_ok", hs_now(), 6'b010000);
        next_cycle();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            mem_addr_ok = (i == 4);
            #1;
            chk($sformatf("store_req_%0d", i), {mem_req, busy}, 2'b11);
            chk($sformatf("store_fields_%0d", i), mem_fields(),
                {1'b1, 2'd0, 4'h2, 32'h1C001001, 32'h0000AB00});
            next_cycle();
        end
        mem_addr_ok = 1'b0;
        #1;
        chk("store_resp_wait", hs_now(), 6'b000100);
        next_cycle();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hFFFFFFFF;
        #1;
        chk("store_done", hs_now(), 6'b000101);
        chk("store_rdata", {inst_rdata, data_rdata}, 64'h0);
        next_cycle();
        idle_inputs();

        // ---------------- reset while waiting for mem_data_ok ----------------
        inst_req  = 1'b1;
        inst_addr = 32'h1C000040;
        next_cycle();
        idle_inputs();
        mem_addr_ok = 1'b1;
        next_cycle();
        mem_addr_ok = 1'b0;
        #1;
        chk("rst_resp_busy", hs_now(), 6'b000100);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_outputs", {hs_now(), mem_req}, 7'b0);
        chk("rst_rdata", {inst_rdata, data_rdata}, 64'h0);
        next_cycle();
        resetn      = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hCAFEF00D;
        inst_req    = 1'b1;
        data_req    = 1'b1;
        data_wr     = 1'b0;
        #1;
        chk("rst_no_pulse_then_tie", hs_now(), 6'b100000);
        chk("rst_no_rdata", {inst_rdata, data_rdata}, 64'h0);

        // ---------------- fetch stream, handshakes always granted ----------------
        do_reset();
        exp_q.delete();
        inst_req    = 1'b1;
        inst_addr   = 32'h1C000000;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        inflight    = 32'h0;
        prev_ok     = -1;
        n_ok        = 0;
        n_gnt       = 0;
        for (int c = 0; c < 32; c++) begin
            mem_rdata = inflight ^ 32'hA5A5A5A5;
            #1;
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected_req", 1'b1, 1'b0);
                end else begin
                    inflight = exp_q.pop_front();
                    chk("stream_order", mem_addr, inflight);
                end
            end
            if (inst_data_ok) begin
                chk("stream_spacing", c - prev_ok, 3);
                chk("stream_rdata", inst_rdata, mem_rdata);
                prev_ok = c;
                n_ok++;
            end
            if (inst_addr_ok) begin
                exp_q.push_back(inst_addr);
                n_gnt++;
            end
            next_cycle();
            if (inst_addr_ok === 1'b0 && n_gnt == 0) begin
                // nothing granted yet; keep holding
            end
            inst_addr = 32'h1C000000 + 32'(n_gnt * 4);
            inst_req  = (n_gnt < 10);
        end
        chk("stream_count", n_ok, 10);

        // ---------------- randomized run against the model ----------------
        do_reset();
        model_reset();
        gi = 1'b0;
        gd = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (!inst_req || gi) begin
                inst_req  = ($urandom_range(0, 1) == 1);
                inst_addr = $urandom;
            end
            if (!data_req || gd) begin
                data_req   = ($urandom_range(0, 1) == 1);
                data_wr    = ($urandom_range(0, 1) == 1);
                data_size  = 2'($urandom_range(0, 2));
                data_wstrb = 4'($urandom_range(0, 15));
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            mem_addr_ok = ($urandom_range(0, 2) != 0);
            mem_data_ok = ($urandom_range(0, 2) != 0);
            mem_rdata   = $urandom;
            #1;
            model_cycle(gi, gd);
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width (fixed at 32; wstrb width DATA_W/8).
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 sole clock, rising edge; resetn in 1 asynchronous active-low reset.
REQ-003 inst_req in 1, inst_addr in 32, inst_addr_ok out 1, inst_data_ok out 1, inst_rdata out 32: read-only fetch requester.
REQ-004 data_req in 1, data_wr in 1, data_size in 2, data_wstrb in 4, data_addr in 32, data_wdata in 32: load/store requester.
REQ-005 data_addr_ok out 1, data_data_ok out 1, data_rdata out 32: load/store requester responses.
REQ-006 mem_req out 1, mem_wr out 1, mem_size out 2, mem_wstrb out 4, mem_addr out 32, mem_wdata out 32: single shared downstream port.
REQ-007 mem_addr_ok in 1, mem_data_ok in 1, mem_rdata in 32: downstream handshake and read data.
REQ-008 busy out 1: high whenever state is not IDLE.

Function
REQ-009 FSM states SHALL be IDLE, REQ, RESP; at most one transaction outstanding.
REQ-010 Requester fields SHALL be sampled only in the cycle its addr_ok is high; requesters hold fields stable while req high and addr_ok low.
REQ-011 IDLE, exactly one req high: assert that requester's addr_ok combinationally that cycle, latch its fields (inst: wr=0, size=2, wstrb=0, wdata=0), record owner, go REQ next cycle.
REQ-012 IDLE, both req high: grant the requester not served last (round-robin via last_owner); other addr_ok stays low.
REQ-013 IDLE, no req: stay IDLE, all addr_ok low.
REQ-014 REQ: mem_req=1 with latched fields; on mem_addr_ok=1 go RESP; else hold all mem_* fields stable.
REQ-015 RESP: mem_req=0; on mem_data_ok=1 pulse owner's data_ok for exactly that cycle, drive owner's rdata = mem_rdata that cycle, update last_owner, go IDLE.
REQ-016 Non-owner data_ok SHALL be 0 always; inst_rdata/data_rdata SHALL be 0 except in owner's data_ok cycle.
REQ-017 No upstream addr_ok SHALL assert in REQ or RESP; minimum upstream req-to-data_ok latency SHALL be 3 cycles (grant, REQ with addr_ok, RESP with data_ok).
REQ-018 mem_data_ok in IDLE or REQ SHALL be ignored; mem_addr_ok outside REQ SHALL be ignored.
REQ-019 Writes SHALL follow the same sequence; data_data_ok marks write completion, data_rdata=0 for writes.
REQ-020 Back-to-back: new grant possible in the IDLE cycle immediately following data_ok (no bubble beyond the IDLE cycle).

Reset
REQ-021 resetn=0 SHALL asynchronously force state=IDLE, last_owner=data (so inst wins first tie), all latched fields 0, busy=0, mem_req=0, all addr_ok/data_ok=0, rdata outputs 0.
REQ-022 Reset mid-transaction SHALL abandon it with no data_ok pulse; first grant after release follows REQ-011/012.

Verification
REQ-023 Single fetch: inst_req=1, addr=0x1C000000 at t0 -> inst_addr_ok t0, mem_req t1 addr 0x1C000000 wr=0 size=2; mem_addr_ok t1, mem_data_ok t2 rdata 0x02800C0C -> inst_data_ok t2, inst_rdata 0x02800C0C.
REQ-024 Tie after reset: both req at t0 -> inst granted; data granted at first IDLE after inst completes; third tie -> inst again.
REQ-025 Store: data_req, wr=1, size=0, wstrb=0x2, addr=0x1C001001, wdata=0x0000AB00 -> identical mem_* fields while REQ; mem_addr_ok delayed 4 cycles -> fields stable throughout; data_data_ok on mem_data_ok, inst_data_ok stays 0.
REQ-026 Spurious handshakes: mem_data_ok pulsed in IDLE and in REQ -> no data_ok output, state unchanged.
REQ-027 Reset in RESP: resetn low 1 cycle before mem_data_ok -> all outputs 0 immediately, no data_ok pulse, busy=0.
REQ-028 Stream: inst_req held high 10 transactions, mem_addr_ok/data_ok always 1 -> one inst_data_ok every 3 cycles, addresses in request order.
